// File: rtl/aexm_fsl_pkg.sv
// Shared constants for the FSL GET/PUT sequencer: state encoding and default sizes.
package aexm_fsl_pkg;

  localparam int FSL_CHW     = 3;
  localparam int FSL_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    FSL_IDLE = 2'd0,
    FSL_BUS  = 2'd1,
    FSL_DONE = 2'd2
  } fsl_state_e;

endpackage

// File: rtl/aexm_fsl_ctrl.sv
// FSL bus sequencer for GET/PUT: holds the pipeline while a transfer is outstanding.
// Optional blocking-wait watchdog enabled by defining AEXM_FSL_TIMEOUT_EN.
module aexm_fsl_ctrl
  import aexm_fsl_pkg::*;
#(
  parameter int CHW     = FSL_CHW,
  parameter int TIMEOUT = FSL_TIMEOUT
) (
  input  logic            gclk,
  input  logic            grst,
  input  logic            op_valid,
  input  logic            op_put,
  input  logic            op_blk,
  input  logic            op_ctl,
  input  logic [CHW-1:0]  op_chan,
  output logic            fsl_stb_o,
  output logic            fsl_we_o,
  output logic [CHW-1:0]  fsl_adr_o,
  output logic            fsl_tag_o,
  input  logic            fsl_ack_i,
  input  logic [31:0]     fsl_dat_i,
  output logic [31:0]     fsl_dat_q,
  output logic            stall_o,
  output logic            done_o,
  output logic            carry_we_o,
  output logic            carry_o,
  output logic            err_o,
  input  logic            err_clr_i,
  output logic [1:0]      dbg_state_o
);

  // Handshake: the request is the op_valid level, held by the stalled pipeline;
  // the bus side is a strobe held until fsl_ack_i (blocking) or for one cycle
  // (non-blocking); done_o closes every accepted request exactly once.

  fsl_state_e       r_state, w_state_nxt;
  logic             r_put, r_blk, r_ctl;
  logic [CHW-1:0]   r_chan;
  logic [31:0]      r_dat;
  logic             r_carry;
  logic             w_bus;
  logic             w_fail;
  logic             w_expire;

  assign w_bus = (r_state == FSL_BUS);

  always_comb begin
    w_state_nxt = r_state;
    w_fail      = 1'b0;
    case (r_state)
      FSL_IDLE: if (op_valid) w_state_nxt = FSL_BUS;
      FSL_BUS: begin
        if (fsl_ack_i) begin
          w_state_nxt = FSL_DONE;
        end else if (!r_blk || w_expire) begin
          w_state_nxt = FSL_DONE;
          w_fail      = 1'b1;
        end
      end
      FSL_DONE: w_state_nxt = FSL_IDLE;
      default:  w_state_nxt = FSL_IDLE;
    endcase
  end

  always_ff @(posedge gclk) begin
    if (grst) begin
      r_state <= FSL_IDLE;
      r_put   <= 1'b0;
      r_blk   <= 1'b0;
      r_ctl   <= 1'b0;
      r_chan  <= '0;
      r_dat   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == FSL_IDLE && op_valid) begin
        r_put  <= op_put;
        r_blk  <= op_blk;
        r_ctl  <= op_ctl;
        r_chan <= op_chan;
      end
      // A PUT leaves the GET data latch untouched.
      if (w_bus && fsl_ack_i) begin
        r_carry <= 1'b0;
        if (!r_put) r_dat <= fsl_dat_i;
      end else if (w_fail) begin
        r_carry <= 1'b1;
      end
    end
  end

`ifdef AEXM_FSL_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_wdt;
  logic          r_err;

  // Counter is held at zero outside BUS, so it starts fresh on each entry.
  always_ff @(posedge gclk) begin
    if (grst || !w_bus) begin
      r_wdt <= '0;
    end else if (r_blk && !fsl_ack_i) begin
      r_wdt <= r_wdt + 1'b1;
    end
  end

  assign w_expire = w_bus && r_blk && !fsl_ack_i && (r_wdt == CW'(TIMEOUT - 1));

  always_ff @(posedge gclk) begin
    if (grst) begin
      r_err <= 1'b0;
    end else if (w_expire) begin
      r_err <= 1'b1;
    end else if (err_clr_i) begin
      r_err <= 1'b0;
    end
  end

  assign err_o = r_err;
`else
  logic        w_unused_clr;
  logic [31:0] w_unused_to;

  assign w_expire     = 1'b0;
  assign err_o        = 1'b0;
  assign w_unused_clr = err_clr_i;
  assign w_unused_to  = 32'(TIMEOUT);
`endif

  assign fsl_stb_o   = w_bus;
  assign fsl_we_o    = w_bus & r_put;
  assign fsl_tag_o   = w_bus & r_ctl;
  assign fsl_adr_o   = r_chan;
  assign fsl_dat_q   = r_dat;
  assign carry_o     = r_carry;
  assign done_o      = (r_state == FSL_DONE);
  assign carry_we_o  = (r_state == FSL_DONE);
  assign stall_o     = ((r_state == FSL_IDLE) && op_valid) || w_bus;
  assign dbg_state_o = r_state;

endmodule

// File: doc/aexm_fsl_ctrl.md
Name: aexm_fsl_ctrl

Overview:
- Sequences GET/PUT instructions onto the FSL bus shared with the register file's FSL data path.
- Holds the pipeline (stall_o, combined into gena upstream) while a transaction is outstanding.
- Latches returned GET data for the load sizer.
- Reports non-blocking failure through a carry update pulse.

Parameters:
- CHW, 3, FSL channel address width (fsl_adr_o).
- TIMEOUT, 1024, blocking-wait watchdog limit in cycles (only with AEXM_FSL_TIMEOUT_EN).

Ports:
- gclk  in  1  clock
- grst  in  1  reset, synchronous, active-high
- op_valid  in  1  registered decode flag, level; held high by the stalled pipeline until done_o
- op_put  in  1  1=PUT, 0=GET
- op_blk  in  1  1=blocking, 0=non-blocking
- op_ctl  in  1  control-word flag
- op_chan  in  CHW  FSL channel
- fsl_stb_o  out  1  bus strobe
- fsl_we_o  out  1  write enable (PUT)
- fsl_adr_o  out  CHW  channel
- fsl_tag_o  out  1  control tag
- fsl_ack_i  in  1  bus acknowledge
- fsl_dat_i  in  32  GET data
- fsl_dat_q  out  32  latched GET data to register file
- stall_o  out  1  pipeline hold
- done_o  out  1  one-cycle completion pulse
- carry_we_o  out  1  MSR[C] write pulse
- carry_o  out  1  MSR[C] value: 1 = failed non-blocking or timeout
- err_o  out  1  sticky timeout flag
- err_clr_i  in  1  clears err_o

Behaviour:
- States: IDLE, BUS, DONE.
- Reset: state=IDLE. fsl_stb_o, fsl_we_o, fsl_tag_o, done_o, carry_we_o, carry_o and err_o are all 0. fsl_adr_o=0, fsl_dat_q=0. Reset mid-transaction drops the strobe at that edge; no done_o is produced.
- stall_o = (IDLE & op_valid) | BUS. It is combinational from op_valid, so op_valid must not depend on gena.
- IDLE:
  - On op_valid, register put/blk/ctl/chan and go to BUS.
  - Bus outputs are driven from registers, so the strobe appears the cycle after op_valid.
- BUS:
  - fsl_stb_o=1, fsl_we_o=put, fsl_adr_o=chan, fsl_tag_o=ctl.
  - If fsl_ack_i: fsl_dat_q<=fsl_dat_i on GET only (unchanged on PUT); carry_o<=0; go to DONE.
  - Else if !blk: carry_o<=1; go to DONE. A non-blocking access therefore gets exactly one strobe cycle.
  - Else: stay in BUS.
  - fsl_stb_o falls on the same edge as the transition to DONE.
- DONE:
  - stall_o=0; done_o=1 and carry_we_o=1 for this single cycle; go to IDLE.
  - op_valid is ignored in DONE, since it still belongs to the completing instruction.
- Back-to-back: an op_valid in the IDLE cycle after DONE starts a new transaction. Minimum 3 cycles per op: IDLE, BUS, DONE.
- An ack outside BUS is ignored.
- err_clr_i clears err_o. If clear and set coincide, set wins.

Optional Feature:
- AEXM_FSL_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT) clears on entry to BUS and increments each blocking BUS cycle without ack.
  - When it reaches TIMEOUT-1 with no ack: carry_o<=1, err_o<=1, go to DONE.
  - An ack in that same cycle wins: normal completion, no error.
- Undefined: blocking waits forever; err_o is tied 0 and err_clr_i is unused.

Decomposition:
- Package aexm_fsl_pkg holds:
  - state encoding constants FSL_IDLE=2'd0, FSL_BUS=2'd1, FSL_DONE=2'd2;
  - default CHW;
  - default TIMEOUT.
- No sub-module is required. The watchdog may be split out as aexm_fsl_wdt (count/expire ports) when the macro is enabled.

Test Plan:
- Blocking GET, chan=5, ack on the 3rd BUS cycle with fsl_dat_i=32'hDEADBEEF:
  - stall_o high 4 cycles; fsl_adr_o=5, fsl_we_o=0 throughout BUS;
  - fsl_dat_q=DEADBEEF; done_o and carry_we_o pulse once with carry_o=0.
- Non-blocking PUT, ctl=1, no ack:
  - exactly one strobe cycle with fsl_we_o=1, fsl_tag_o=1;
  - done_o pulse with carry_o=1; fsl_dat_q unchanged.
- Non-blocking GET acked in its single BUS cycle with data 32'h12345678: carry_o=0, fsl_dat_q=12345678.
- Back-to-back PUT then GET, each acked immediately:
  - two transactions 3 cycles apart; stall_o low only in each DONE cycle;
  - op_valid held during DONE is not re-accepted.
- grst asserted during a blocking BUS wait: next cycle state=IDLE, strobe 0, no done_o; a late ack afterwards has no effect.
- With AEXM_FSL_TIMEOUT_EN and TIMEOUT=8, blocking GET, no ack:
  - DONE after 8 BUS cycles with carry_o=1; err_o set and remains set;
  - err_clr_i pulse clears it; an ack on cycle 8 instead gives carry_o=0 and err_o=0.
